// File: rtl/hawk_capture_sequencer.sv
// hawk_capture_sequencer: arms on capture, forwards one camera frame to the S2MM DMA stream with tlast,
// discards camera data otherwise, and reports busy/done/errors/frame count.
module hawk_capture_sequencer #(
  parameter int          DATA_W         = 64,
  parameter int          PIX_PER_BEAT   = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                capture,
  input  logic                abort,
  input  logic [15:0]         cfg_width,
  input  logic [15:0]         cfg_height,
  input  logic                frame_sync,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                busy,
  output logic                done,
  output logic                err_config,
  output logic                err_timeout,
  output logic                err_abort,
  output logic [15:0]         frames_captured
);
  typedef enum logic [1:0] {IDLE, ARM, STREAM, DONE} state_t;
  localparam logic [15:0] PPB = 16'(PIX_PER_BEAT);
  state_t      state_q, state_d;
  logic [15:0] bpl_q, bpl_d, height_q, height_d, beat_q, beat_d, line_q, line_d, frames_q, frames_d;
  logic [31:0] wdog_q, wdog_d;
  logic        abort_pend_q, abort_pend_d, err_config_q, err_config_d;
  logic        err_timeout_q, err_timeout_d, err_abort_q, err_abort_d;
  logic        in_stream, cfg_ok, forced, last_beat, line_end, xfer, wdog_hit;
  assign in_stream = state_q == STREAM;
  assign cfg_ok    = cfg_width != 16'd0 && cfg_height != 16'd0 && (cfg_width % PPB) == 16'd0;
  // an abort in the same cycle as a transfer turns that beat into the closing one
  assign forced    = abort_pend_q || abort;
  assign line_end  = beat_q == bpl_q - 16'd1;
  assign last_beat = line_end && line_q == height_q - 16'd1;
  assign xfer      = in_stream && s_tvalid && m_tready;
  assign wdog_hit  = wdog_q == TIMEOUT_CYCLES - 32'd1;
  assign m_tdata         = s_tdata;
  assign m_tvalid        = in_stream && s_tvalid;
  assign m_tlast         = in_stream && (forced || last_beat);
  assign m_tkeep         = in_stream ? '1 : '0;
  assign s_tready        = in_stream ? m_tready : state_q != DONE;
  assign busy            = state_q == ARM || in_stream;
  assign done            = state_q == DONE;
  assign err_config      = err_config_q;
  assign err_timeout     = err_timeout_q;
  assign err_abort       = err_abort_q;
  assign frames_captured = frames_q;
  always_comb begin
    state_d       = state_q;
    bpl_d         = bpl_q;
    height_d      = height_q;
    beat_d        = beat_q;
    line_d        = line_q;
    frames_d      = frames_q;
    wdog_d        = wdog_q;
    abort_pend_d  = abort_pend_q;
    err_config_d  = err_config_q;
    err_timeout_d = err_timeout_q;
    err_abort_d   = err_abort_q;
    case (state_q)
      IDLE: if (capture) begin
        err_config_d  = !cfg_ok;
        err_timeout_d = 1'b0;
        err_abort_d   = 1'b0;
        if (cfg_ok) begin
          bpl_d        = cfg_width / PPB;
          height_d     = cfg_height;
          beat_d       = 16'd0;
          line_d       = 16'd0;
          wdog_d       = 32'd0;
          abort_pend_d = 1'b0;
          state_d      = ARM;
        end
      end
      ARM: begin
        wdog_d = wdog_q + 32'd1;
        if (abort) begin
          err_abort_d = 1'b1;
          state_d     = IDLE;
        end else if (frame_sync) begin
          wdog_d  = 32'd0;
          state_d = STREAM;
        end else if (wdog_hit) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      STREAM: begin
        abort_pend_d = forced;
        wdog_d       = wdog_q + 32'd1;
        if (xfer) begin
          wdog_d = 32'd0;
          beat_d = line_end ? 16'd0 : beat_q + 16'd1;
          line_d = line_end ? line_q + 16'd1 : line_q;
          if (forced) begin
            err_abort_d = 1'b1;
            state_d     = IDLE;
          end else if (last_beat) begin
            state_d = DONE;
          end
        end else if (wdog_hit) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        frames_d = frames_q + 16'd1;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      bpl_q         <= 16'd0;
      height_q      <= 16'd0;
      beat_q        <= 16'd0;
      line_q        <= 16'd0;
      frames_q      <= 16'd0;
      wdog_q        <= 32'd0;
      abort_pend_q  <= 1'b0;
      err_config_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_abort_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bpl_q         <= bpl_d;
      height_q      <= height_d;
      beat_q        <= beat_d;
      line_q        <= line_d;
      frames_q      <= frames_d;
      wdog_q        <= wdog_d;
      abort_pend_q  <= abort_pend_d;
      err_config_q  <= err_config_d;
      err_timeout_q <= err_timeout_d;
      err_abort_q   <= err_abort_d;
    end
  end
endmodule
